// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin synchroniser, debouncer, edge events,
// sticky interrupt status with write-1-to-clear, and a registered irq.
module gpio_in_cond #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          pclk,
  input  logic          n_p_reset,
  input  logic [DW-1:0] gpio_pin_in,
  input  logic [DW-1:0] n_gpio_pin_oe,
  input  logic [CW-1:0] db_limit,
  input  logic [DW-1:0] int_rise_en,
  input  logic [DW-1:0] int_fall_en,
  input  logic [DW-1:0] int_mask,
  input  logic          clr_valid,
  input  logic [DW-1:0] clr_data,
  output logic [DW-1:0] gpio_in_db,
  output logic [DW-1:0] int_status,
  output logic          irq
);

  localparam logic [CW:0] one_w = {{CW{1'b0}}, 1'b1};

  logic [DW-1:0] sync1;
  logic [DW-1:0] sync2;
  logic [DW-1:0] rise;
  logic [DW-1:0] fall;
  logic [DW-1:0] set_vec;
  logic [DW-1:0] clr_vec;
  logic [CW:0]   limit_eff;

  // A limit of 0 is treated as 1; one extra bit keeps cnt+1 from wrapping.
  always_comb begin
    limit_eff = (db_limit == '0) ? one_w : {1'b0, db_limit};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours (sync1 -> sync2 needs exactly that).
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_pin_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < DW; i++) begin : g_pin
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          db_q;
    logic          rise_q;
    logic          fall_q;

    assign cnt_inc = {1'b0, cnt} + one_w;

    // NOTE: the debounce counters are individual flops, not a RAM, so they are
    // reset like any other state; a reset mid-count must discard the count.
    always_ff @(posedge pclk or negedge n_p_reset) begin
      if (!n_p_reset) begin
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync2[i] == db_q) begin
          cnt <= '0;
        end else if (cnt_inc >= limit_eff) begin
          db_q   <= sync2[i];
          cnt    <= '0;
          rise_q <= sync2[i] & n_gpio_pin_oe[i];
          fall_q <= ~sync2[i] & n_gpio_pin_oe[i];
        end else if (cnt != '1) begin
          cnt <= cnt_inc[CW-1:0];
        end
      end
    end

    assign gpio_in_db[i] = db_q;
    assign rise[i]       = rise_q;
    assign fall[i]       = fall_q;
  end

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise a latch is inferred.
  always_comb begin
    set_vec = (rise & int_rise_en) | (fall & int_fall_en);
    clr_vec = clr_valid ? clr_data : '0;
  end

  // Set is applied after clear, so a same-cycle set wins.
  always_ff @(posedge pclk or negedge n_p_reset) begin
    if (!n_p_reset) begin
      int_status <= '0;
      irq        <= 1'b0;
    end else begin
      int_status <= (int_status & ~clr_vec) | set_vec;
      irq        <= |(int_status & int_mask);
    end
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Self-checking bench for gpio_in_cond: directed scenarios with hand-derived
// timing plus a randomized run against a behavioural model.
module tb_gpio_in_cond;
  localparam int DW = 16;
  localparam int CW = 8;

  logic          pclk = 1'b0;
  logic          n_p_reset = 1'b0;
  logic [DW-1:0] gpio_pin_in = '0;
  logic [DW-1:0] n_gpio_pin_oe = '1;
  logic [CW-1:0] db_limit = 8'd4;
  logic [DW-1:0] int_rise_en = '0;
  logic [DW-1:0] int_fall_en = '0;
  logic [DW-1:0] int_mask = '0;
  logic          clr_valid = 1'b0;
  logic [DW-1:0] clr_data = '0;
  logic [DW-1:0] gpio_in_db;
  logic [DW-1:0] int_status;
  logic          irq;

  int checks = 0;
  int passes = 0;

  gpio_in_cond #(.DW(DW), .CW(CW)) dut (
    .pclk(pclk), .n_p_reset(n_p_reset), .gpio_pin_in(gpio_pin_in),
    .n_gpio_pin_oe(n_gpio_pin_oe), .db_limit(db_limit),
    .int_rise_en(int_rise_en), .int_fall_en(int_fall_en), .int_mask(int_mask),
    .clr_valid(clr_valid), .clr_data(clr_data), .gpio_in_db(gpio_in_db),
    .int_status(int_status), .irq(irq)
  );

  always #5 pclk = ~pclk;

  // Behavioural model: a pin's debounced value follows the synchronised input
  // once that input has disagreed with it for 'limit' consecutive cycles.
  logic [DW-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_stat;
  logic          m_irq;
  int            m_age [DW];

  always @(posedge pclk or negedge n_p_reset) begin : model
    int lim;
    int age [DW];
    logic [DW-1:0] ndb, nr, nf, clr;
    if (!n_p_reset) begin
      m_s1 <= '0; m_s2 <= '0; m_db <= '0; m_rise <= '0; m_fall <= '0;
      m_stat <= '0; m_irq <= 1'b0;
      for (int i = 0; i < DW; i++) m_age[i] <= 0;
    end else begin
      lim = (db_limit == 0) ? 1 : int'(db_limit);
      ndb = m_db; nr = '0; nf = '0;
      for (int i = 0; i < DW; i++) begin
        age[i] = m_age[i];
        if (m_s2[i] == m_db[i]) age[i] = 0;
        else if (age[i] + 1 >= lim) begin
          ndb[i] = m_s2[i];
          age[i] = 0;
          if (n_gpio_pin_oe[i]) begin
            nr[i] = m_s2[i];
            nf[i] = !m_s2[i];
          end
        end else age[i] = age[i] + 1;
      end
      clr = clr_valid ? clr_data : '0;
      m_irq  <= |(m_stat & int_mask);
      m_stat <= (m_stat & ~clr) | (m_rise & int_rise_en) | (m_fall & int_fall_en);
      m_rise <= nr; m_fall <= nf; m_db <= ndb;
      m_s2 <= m_s1; m_s1 <= gpio_pin_in;
      for (int i = 0; i < DW; i++) m_age[i] <= age[i];
    end
  end

  task automatic wait_event(input int pin, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge pclk);
      if (m_rise[pin] || m_fall[pin]) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    gpio_pin_in = 16'hA5C3;
    repeat (3) @(negedge pclk);
    checks++;
    if ({gpio_in_db, int_status, irq} !== '0)
      $display("FAIL reset_hold: db=%h st=%h irq=%b, want all 0", gpio_in_db, int_status, irq);
    else passes++;
    gpio_pin_in = '0;
    n_p_reset = 1'b1;
    repeat (8) @(negedge pclk);
    checks++;
    if ({gpio_in_db, int_status, irq} !== '0)
      $display("FAIL reset_idle: db=%h st=%h irq=%b, want all 0", gpio_in_db, int_status, irq);
    else passes++;
  endtask

  task automatic test_debounce_latency();
    logic [2:0] want;
    db_limit = 8'd4; n_gpio_pin_oe = '1;
    int_rise_en = 16'h0001; int_fall_en = '0; int_mask = 16'h0001;
    gpio_pin_in[0] = 1'b1;  // stable before the next edge, called edge k
    for (int e = 0; e < 8; e++) begin
      @(negedge pclk);
      want = {e >= 5, e >= 6, e >= 7};
      checks++;
      if ({gpio_in_db[0], int_status[0], irq} !== want)
        $display("FAIL latency k+%0d: db0/st0/irq=%b%b%b want %b", e,
                 gpio_in_db[0], int_status[0], irq, want);
      else passes++;
    end
  endtask

  task automatic test_glitch();
    clr_valid = 1'b1; clr_data = 16'h0001;
    @(negedge pclk);
    clr_valid = 1'b0; clr_data = '0;
    int_mask = '1; int_rise_en = 16'h0005;
    repeat (2) @(negedge pclk);
    checks++;
    if (int_status !== '0 || irq !== 1'b0)
      $display("FAIL glitch_pre: st=%h irq=%b want 0000/0", int_status, irq);
    else passes++;
    gpio_pin_in[2] = 1'b1;
    repeat (3) @(negedge pclk);
    gpio_pin_in[2] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      @(negedge pclk);
      checks++;
      if (gpio_in_db[2] !== 1'b0 || int_status !== '0 || irq !== 1'b0)
        $display("FAIL glitch c%0d: db2=%b st=%h irq=%b want 0/0000/0", e,
                 gpio_in_db[2], int_status, irq);
      else passes++;
    end
  endtask

  task automatic test_clear_collision();
    bit ok;
    int_fall_en = 16'h0001; int_rise_en = 16'h0005; int_mask = '1;
    gpio_pin_in[0] = 1'b0;
    wait_event(0, ok);
    @(negedge pclk);
    gpio_pin_in[2] = 1'b1;
    wait_event(2, ok);
    @(negedge pclk);
    checks++;
    if (!ok || int_status !== 16'h0005)
      $display("FAIL coll_setup: ok=%b st=%h want 0005", ok, int_status);
    else passes++;
    gpio_pin_in[2] = 1'b0;
    repeat (8) @(negedge pclk);
    gpio_pin_in[2] = 1'b1;
    wait_event(2, ok);
    clr_valid = 1'b1; clr_data = 16'h0001;
    @(negedge pclk);
    clr_valid = 1'b0; clr_data = '0;
    checks++;
    if (!ok || int_status !== 16'h0004)
      $display("FAIL coll_clr_other: ok=%b st=%h want 0004", ok, int_status);
    else passes++;
    gpio_pin_in[2] = 1'b0;
    repeat (8) @(negedge pclk);
    gpio_pin_in[2] = 1'b1;
    wait_event(2, ok);
    clr_valid = 1'b1; clr_data = 16'h0004;
    @(negedge pclk);
    clr_valid = 1'b0; clr_data = '0;
    checks++;
    if (!ok || int_status !== 16'h0004)
      $display("FAIL coll_set_wins: ok=%b st=%h want 0004", ok, int_status);
    else passes++;
    clr_valid = 1'b1; clr_data = 16'h0004;
    @(negedge pclk);
    clr_valid = 1'b0; clr_data = '0;
    checks++;
    if (int_status !== 16'h0000)
      $display("FAIL coll_plain_clr: st=%h want 0000", int_status);
    else passes++;
  endtask

  task automatic test_output_mode();
    n_gpio_pin_oe[3] = 1'b0; int_rise_en[3] = 1'b1; int_fall_en[3] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      gpio_pin_in[3] = ~gpio_pin_in[3];
      repeat (8) @(negedge pclk);
      checks++;
      if (gpio_in_db[3] !== gpio_pin_in[3] || int_status[3] !== 1'b0)
        $display("FAIL out_mode t%0d: db3=%b st3=%b want %b/0", t,
                 gpio_in_db[3], int_status[3], gpio_pin_in[3]);
      else passes++;
    end
    n_gpio_pin_oe[3] = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] wdb, wst;
    db_limit = 8'd4;
    gpio_pin_in[1] = 1'b1;
    repeat (4) @(negedge pclk);  // pin 1 count now at 2
    #2 n_p_reset = 1'b0;
    #1;
    checks++;
    if ({gpio_in_db, int_status, irq} !== '0)
      $display("FAIL rst_async: db=%h st=%h irq=%b want all 0", gpio_in_db, int_status, irq);
    else passes++;
    gpio_pin_in = 16'h0022; int_rise_en = 16'h0022; int_fall_en = '0; int_mask = 16'h0022;
    repeat (2) @(negedge pclk);
    n_p_reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      @(negedge pclk);
      wdb = (e >= 5) ? 16'h0022 : 16'h0000;
      wst = (e >= 6) ? 16'h0022 : 16'h0000;
      checks++;
      if (gpio_in_db !== wdb || int_status !== wst || irq !== (e >= 7))
        $display("FAIL rst_release k+%0d: db=%h st=%h irq=%b want %h/%h/%b", e,
                 gpio_in_db, int_status, irq, wdb, wst, e >= 7);
      else passes++;
    end
  endtask

  task automatic test_limit_change();
    db_limit = 8'd200;
    gpio_pin_in[6] = 1'b1;
    repeat (7) @(negedge pclk);  // pin 6 count now at 5
    checks++;
    if (gpio_in_db[6] !== 1'b0) $display("FAIL lim_before: db6=%b want 0", gpio_in_db[6]);
    else passes++;
    db_limit = 8'd3;
    @(negedge pclk);
    checks++;
    if (gpio_in_db[6] !== 1'b1) $display("FAIL lim_lowered: db6=%b want 1", gpio_in_db[6]);
    else passes++;
    db_limit = 8'd0;
    gpio_pin_in[7] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(negedge pclk);
      checks++;
      if (gpio_in_db[7] !== (e >= 2))
        $display("FAIL lim_zero k+%0d: db7=%b want %b", e, gpio_in_db[7], e >= 2);
      else passes++;
    end
  endtask

  task automatic test_random();
    int idx;
    for (int c = 0; c < 3000; c++) begin
      @(negedge pclk);
      checks++;
      if (gpio_in_db !== m_db || int_status !== m_stat || irq !== m_irq)
        $display("FAIL random c%0d: db=%h st=%h irq=%b want %h/%h/%b", c,
                 gpio_in_db, int_status, irq, m_db, m_stat, m_irq);
      else passes++;
      n_p_reset = 1'b1;
      clr_valid = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, DW - 1);
        gpio_pin_in[idx] = ~gpio_pin_in[idx];
      end
      if ($urandom_range(0, 60) == 0)
        db_limit = ($urandom_range(0, 9) == 0) ? 8'd20 : CW'($urandom_range(0, 6));
      if ($urandom_range(0, 80) == 0) begin
        int_rise_en = DW'($urandom); int_fall_en = DW'($urandom);
        int_mask = DW'($urandom); n_gpio_pin_oe = DW'($urandom);
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_valid = 1'b1; clr_data = DW'($urandom);
      end
      if ($urandom_range(0, 400) == 0) n_p_reset = 1'b0;
    end
    n_p_reset = 1'b1; clr_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_clear_collision();
    test_output_mode();
    test_reset_mid();
    test_limit_change();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
